// File: rtl/dm_lsu_pkg.sv
// Shared types for the data-memory load/store unit: request opcodes, FSM states
// and opcode classification helpers.
package dm_lsu_pkg;

  typedef enum logic [2:0] {
    LSU_OP_LW  = 3'b000,
    LSU_OP_LH  = 3'b001,
    LSU_OP_LHU = 3'b010,
    LSU_OP_LB  = 3'b011,
    LSU_OP_LBU = 3'b100,
    LSU_OP_SW  = 3'b101,
    LSU_OP_SH  = 3'b110,
    LSU_OP_SB  = 3'b111
  } lsu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_WRITE  = 2'b10,
    ST_RESP   = 2'b11
  } lsu_state_e;

  function automatic logic is_store(input lsu_op_e op);
    return (op == LSU_OP_SW) || (op == LSU_OP_SH) || (op == LSU_OP_SB);
  endfunction

  function automatic logic is_sub_word(input lsu_op_e op);
    return (op == LSU_OP_LH) || (op == LSU_OP_LHU) || (op == LSU_OP_LB) ||
           (op == LSU_OP_LBU) || (op == LSU_OP_SH) || (op == LSU_OP_SB);
  endfunction

endpackage

// File: rtl/dm_lane_merge.sv
// Little-endian lane logic: extracts and extends sub-word load data, and merges
// a store byte/halfword into the old memory word for read-modify-write.
module dm_lane_merge
  import dm_lsu_pkg::*;
(
  input  logic [2:0]  i_op,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_mem_word,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load_data,
  output logic [31:0] o_merged_word
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  lsu_op_e     w_op;

  assign w_op   = lsu_op_e'(i_op);
  assign w_byte = i_mem_word[{i_addr_lo, 3'b000} +: 8];
  assign w_half = i_mem_word[{i_addr_lo[1], 4'b0000} +: 16];

  // Load result: pick the lane, then sign- or zero-extend
  always_comb begin
    o_load_data = 32'd0;
    case (w_op)
      LSU_OP_LW:  o_load_data = i_mem_word;
      LSU_OP_LH:  o_load_data = {{16{w_half[15]}}, w_half};
      LSU_OP_LHU: o_load_data = {16'd0, w_half};
      LSU_OP_LB:  o_load_data = {{24{w_byte[7]}}, w_byte};
      LSU_OP_LBU: o_load_data = {24'd0, w_byte};
      default:    o_load_data = 32'd0;
    endcase
  end

  // Store merge: old word with only the addressed lane replaced
  always_comb begin
    o_merged_word = i_mem_word;
    case (w_op)
      LSU_OP_SB: o_merged_word[{i_addr_lo, 3'b000} +: 8]     = i_wdata[7:0];
      LSU_OP_SH: o_merged_word[{i_addr_lo[1], 4'b0000} +: 16] = i_wdata[15:0];
      default:   o_merged_word = i_mem_word;
    endcase
  end

endmodule

// File: rtl/dm_load_store_unit.sv
// Load/store unit over a word-only, single-cycle data memory; sub-word stores use
// read-modify-write. Optional macro MISALIGN_TRAP_EN traps misaligned LW/SW/LH/LHU/SH.
module dm_load_store_unit
  import dm_lsu_pkg::*;
#(
  parameter int WL           = 32,
  parameter int MEMORY_WIDTH = 32,
  parameter int MEMORY_DEPTH = 50
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    LSU_Req_Valid,
  output logic                    LSU_Req_Ready,
  input  logic [2:0]              LSU_Req_Op,
  input  logic [WL-1:0]           LSU_Req_Addr,
  input  logic [31:0]             LSU_Req_Wdata,
  output logic                    LSU_Resp_Valid,
  output logic [31:0]             LSU_Resp_Rdata,
  output logic                    LSU_Resp_Err,
  output logic [WL-1:0]           DM_Input_Address,
  output logic [MEMORY_WIDTH-1:0] DM_Data_To_Write,
  output logic                    DM_Write_Enable_Flag,
  input  logic [MEMORY_WIDTH-1:0] DM_Output_Data
);

  lsu_state_e            r_state;
  lsu_op_e               r_op;
  logic [WL-1:0]         r_addr;
  logic [31:0]           r_dm_wdata;
  logic                  r_oor;
  logic                  r_misalign;
  logic                  r_we;
  logic                  r_ready;
  logic                  r_resp_valid;
  logic                  r_resp_err;
  logic [31:0]           r_rdata;

  lsu_op_e               w_req_op;
  logic                  w_accept;
  logic                  w_req_oor;
  logic                  w_req_misalign;
  logic [31:0]           w_load_data;
  logic [31:0]           w_merged_word;

  assign w_req_op  = lsu_op_e'(LSU_Req_Op);
  assign w_accept  = LSU_Req_Valid & r_ready;
  assign w_req_oor = (LSU_Req_Addr >> 2) >= WL'(MEMORY_DEPTH);

`ifdef MISALIGN_TRAP_EN
  // Alignment trap for word and halfword accesses
  always_comb begin
    w_req_misalign = 1'b0;
    case (w_req_op)
      LSU_OP_LW, LSU_OP_SW:             w_req_misalign = (LSU_Req_Addr[1:0] != 2'b00);
      LSU_OP_LH, LSU_OP_LHU, LSU_OP_SH: w_req_misalign = LSU_Req_Addr[0];
      default:                          w_req_misalign = 1'b0;
    endcase
  end
`else
  assign w_req_misalign = 1'b0;
`endif

  dm_lane_merge u_lane_merge (
    .i_op          (r_op),
    .i_addr_lo     (r_addr[1:0]),
    .i_mem_word    (DM_Output_Data),
    .i_wdata       (r_dm_wdata),
    .o_load_data   (w_load_data),
    .o_merged_word (w_merged_word)
  );

  // Request FSM: IDLE -> ACCESS -> [WRITE] -> RESP -> IDLE
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= ST_IDLE;
      r_op         <= LSU_OP_LW;
      r_addr       <= '0;
      r_dm_wdata   <= 32'd0;
      r_oor        <= 1'b0;
      r_misalign   <= 1'b0;
      r_we         <= 1'b0;
      r_ready      <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_rdata      <= 32'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op       <= w_req_op;
            r_addr     <= LSU_Req_Addr;
            r_dm_wdata <= LSU_Req_Wdata;
            r_oor      <= w_req_oor;
            r_misalign <= w_req_misalign;
            r_we       <= (w_req_op == LSU_OP_SW) && !w_req_oor && !w_req_misalign;
            r_ready    <= 1'b0;
            r_state    <= ST_ACCESS;
          end else begin
            r_ready    <= 1'b1;
          end
        end
        ST_ACCESS: begin
          // Trapped sub-word stores skip the write cycle entirely
          if (is_store(r_op) && is_sub_word(r_op) && !r_misalign) begin
            r_dm_wdata <= w_merged_word;
            r_we       <= !r_oor;
            r_state    <= ST_WRITE;
          end else begin
            r_we         <= 1'b0;
            r_resp_valid <= 1'b1;
            r_resp_err   <= r_oor | r_misalign;
            r_state      <= ST_RESP;
          end
          r_rdata <= (is_store(r_op) || r_oor || r_misalign) ? 32'd0 : w_load_data;
        end
        ST_WRITE: begin
          r_we         <= 1'b0;
          r_resp_valid <= 1'b1;
          r_resp_err   <= r_oor;
          r_state      <= ST_RESP;
        end
        ST_RESP: begin
          r_resp_valid <= 1'b0;
          r_resp_err   <= 1'b0;
          r_ready      <= 1'b1;
          r_state      <= ST_IDLE;
        end
        default: begin
          r_we         <= 1'b0;
          r_resp_valid <= 1'b0;
          r_resp_err   <= 1'b0;
          r_ready      <= 1'b1;
          r_state      <= ST_IDLE;
        end
      endcase
    end
  end

  assign LSU_Req_Ready        = r_ready;
  assign LSU_Resp_Valid       = r_resp_valid;
  assign LSU_Resp_Rdata       = r_rdata;
  assign LSU_Resp_Err         = r_resp_err;
  assign DM_Input_Address     = {2'b00, r_addr[WL-1:2]};
  assign DM_Data_To_Write     = r_dm_wdata;
  // A reset edge must never coincide with a memory write
  assign DM_Write_Enable_Flag = r_we & ~RST;

endmodule

// File: tb/tb_dm_load_store_unit.sv
// Directed self-checking bench for dm_load_store_unit with a 50-word behavioural
// memory (combinational read, write at posedge).
module tb_dm_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = 3'b000;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_we;
  logic [31:0] dm_rdata;

  logic [31:0] mem [0:49];
  logic        mem_clr = 1'b1;
  logic        pl_en = 1'b0;
  logic [5:0]  pl_idx = 6'd0;
  logic [31:0] pl_data = 32'd0;

  int we_count = 0;
  int resp_count = 0;
  logic [31:0] we_addr = 32'd0;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dm_load_store_unit dut (
    .CLK                  (clk),
    .RST                  (rst),
    .LSU_Req_Valid        (req_valid),
    .LSU_Req_Ready        (req_ready),
    .LSU_Req_Op           (req_op),
    .LSU_Req_Addr         (req_addr),
    .LSU_Req_Wdata        (req_wdata),
    .LSU_Resp_Valid       (resp_valid),
    .LSU_Resp_Rdata       (resp_rdata),
    .LSU_Resp_Err         (resp_err),
    .DM_Input_Address     (dm_addr),
    .DM_Data_To_Write     (dm_wdata),
    .DM_Write_Enable_Flag (dm_we),
    .DM_Output_Data       (dm_rdata)
  );

  assign dm_rdata = (dm_addr < 32'd50) ? mem[dm_addr[5:0]] : 32'd0;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 50; i++) mem[i] <= 32'd0;
    end else if (pl_en) begin
      mem[pl_idx] <= pl_data;
    end else if (dm_we && dm_addr < 32'd50) begin
      mem[dm_addr[5:0]] <= dm_wdata;
    end
  end

  always @(posedge clk) begin
    if (dm_we) begin
      we_count <= we_count + 1;
      we_addr  <= dm_addr;
    end
    if (resp_valid) resp_count <= resp_count + 1;
  end

  task automatic preload(input logic [5:0] idx, input logic [31:0] data);
    @(negedge clk);
    pl_idx = idx; pl_data = data; pl_en = 1'b1;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  // Issue one request and capture the response; lat = edges from accept to Resp_Valid
  task automatic do_req(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd, output logic err);
    @(negedge clk);
    req_op = op; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    lat = 0; rd = 32'hXXXXXXXX; err = 1'bx;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (i == 1) req_valid = 1'b0;
      if (resp_valid) begin
        lat = i; rd = resp_rdata; err = resp_err;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; mem_clr = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", req_ready); end
    tests++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
    tests++; if (resp_rdata !== 32'd0) begin fails++; $display("FAIL reset_rdata: got %h want 0", resp_rdata); end
    tests++; if (resp_err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", resp_err); end
    tests++; if (dm_we !== 1'b0 || dm_addr !== 32'd0 || dm_wdata !== 32'd0) begin
      fails++; $display("FAIL reset_dm: we=%b addr=%h data=%h want 0/0/0", dm_we, dm_addr, dm_wdata);
    end
    rst = 1'b0; mem_clr = 1'b0;
    begin
      int we0, rc0, bad;
      we0 = we_count; rc0 = resp_count; bad = 0;
      for (int i = 0; i < 20; i++) begin
        @(posedge clk); #1;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) bad++;
      end
      tests++; if (bad != 0) begin fails++; $display("FAIL idle_ready: %0d bad cycles want 0", bad); end
      tests++; if (we_count != we0 || resp_count != rc0) begin
        fails++; $display("FAIL idle_quiet: we %0d resp %0d want 0/0", we_count - we0, resp_count - rc0);
      end
    end
  endtask

  task automatic test_word;
    int lat, we0; logic [31:0] rd; logic err;
    we0 = we_count;
    do_req(3'b101, 32'h10, 32'hDEADBEEF, lat, rd, err);
    tests++; if (lat != 2) begin fails++; $display("FAIL sw_latency: got %0d want 2", lat); end
    tests++; if (we_count - we0 != 1 || we_addr !== 32'd4) begin
      fails++; $display("FAIL sw_we: pulses %0d idx %h want 1 @4", we_count - we0, we_addr);
    end
    tests++; if (mem[4] !== 32'hDEADBEEF) begin fails++; $display("FAIL sw_mem: got %h want deadbeef", mem[4]); end
    tests++; if (rd !== 32'd0 || err !== 1'b0) begin fails++; $display("FAIL sw_resp: rd %h err %b want 0/0", rd, err); end
    we0 = we_count;
    do_req(3'b000, 32'h10, 32'd0, lat, rd, err);
    tests++; if (lat != 2) begin fails++; $display("FAIL lw_latency: got %0d want 2", lat); end
    tests++; if (rd !== 32'hDEADBEEF) begin fails++; $display("FAIL lw_rdata: got %h want deadbeef", rd); end
    tests++; if (we_count != we0) begin fails++; $display("FAIL lw_no_we: %0d pulses want 0", we_count - we0); end
    tests++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      fails++; $display("FAIL resp_pulse: valid %b ready %b want 0/1", resp_valid, req_ready);
    end
  endtask

  task automatic test_subword;
    int lat, we0; logic [31:0] rd; logic err;
    we0 = we_count;
    do_req(3'b111, 32'h12, 32'h00000055, lat, rd, err);
    tests++; if (lat != 3) begin fails++; $display("FAIL sb_latency: got %0d want 3", lat); end
    tests++; if (mem[4] !== 32'hDE55BEEF) begin fails++; $display("FAIL sb_mem: got %h want de55beef", mem[4]); end
    tests++; if (we_count - we0 != 1) begin fails++; $display("FAIL sb_we: %0d pulses want 1", we_count - we0); end
    do_req(3'b011, 32'h13, 32'd0, lat, rd, err);
    tests++; if (rd !== 32'hFFFFFFDE) begin fails++; $display("FAIL lb_rdata: got %h want ffffffde", rd); end
    do_req(3'b100, 32'h13, 32'd0, lat, rd, err);
    tests++; if (rd !== 32'h000000DE || lat != 2) begin fails++; $display("FAIL lbu_rdata: got %h lat %0d want 000000de/2", rd, lat); end
    do_req(3'b110, 32'h10, 32'h00008001, lat, rd, err);
    tests++; if (mem[4] !== 32'hDE558001 || lat != 3) begin fails++; $display("FAIL sh_mem: got %h lat %0d want de558001/3", mem[4], lat); end
    do_req(3'b001, 32'h10, 32'd0, lat, rd, err);
    tests++; if (rd !== 32'hFFFF8001) begin fails++; $display("FAIL lh_rdata: got %h want ffff8001", rd); end
    do_req(3'b010, 32'h10, 32'd0, lat, rd, err);
    tests++; if (rd !== 32'h00008001) begin fails++; $display("FAIL lhu_rdata: got %h want 00008001", rd); end
    do_req(3'b001, 32'h12, 32'd0, lat, rd, err);
    tests++; if (rd !== 32'hFFFFDE55) begin fails++; $display("FAIL lh_upper: got %h want ffffde55", rd); end
  endtask

  task automatic test_out_of_range;
    int lat, we0; logic [31:0] rd; logic err;
    preload(6'd0, 32'hCAFEF00D);
    we0 = we_count;
    do_req(3'b101, 32'd200, 32'h12345678, lat, rd, err);
    tests++; if (err !== 1'b1 || rd !== 32'd0 || lat != 2) begin
      fails++; $display("FAIL oor_sw: err %b rd %h lat %0d want 1/0/2", err, rd, lat);
    end
    do_req(3'b111, 32'd201, 32'h000000AA, lat, rd, err);
    tests++; if (err !== 1'b1 || lat != 3) begin fails++; $display("FAIL oor_sb: err %b lat %0d want 1/3", err, lat); end
    tests++; if (we_count != we0) begin fails++; $display("FAIL oor_no_we: %0d pulses want 0", we_count - we0); end
    do_req(3'b000, 32'd0, 32'd0, lat, rd, err);
    tests++; if (rd !== 32'hCAFEF00D || err !== 1'b0) begin fails++; $display("FAIL lw_after_oor: rd %h err %b want cafef00d/0", rd, err); end
  endtask

  task automatic test_reset_mid;
    int we0, rc0;
    preload(6'd5, 32'h11223344);
    we0 = we_count; rc0 = resp_count;
    @(negedge clk);
    req_op = 3'b111; req_addr = 32'h14; req_wdata = 32'h000000AA; req_valid = 1'b1;
    @(posedge clk); #1; req_valid = 1'b0;
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL rst_write_ready: got %b want 1", req_ready); end
    @(negedge clk);
    req_op = 3'b101; req_addr = 32'h14; req_wdata = 32'hFFFFFFFF; req_valid = 1'b1;
    @(posedge clk); #1; req_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    tests++; if (mem[5] !== 32'h11223344) begin fails++; $display("FAIL rst_mem: got %h want 11223344", mem[5]); end
    tests++; if (we_count != we0) begin fails++; $display("FAIL rst_no_we: %0d pulses want 0", we_count - we0); end
    tests++; if (resp_count != rc0) begin fails++; $display("FAIL rst_no_resp: %0d responses want 0", resp_count - rc0); end
  endtask

  task automatic test_back_to_back;
    int rc0, busy_ready;
    rc0 = resp_count;
    @(negedge clk);
    req_op = 3'b000; req_addr = 32'h10; req_wdata = 32'd0; req_valid = 1'b1;
    @(posedge clk); #1; busy_ready = req_ready;
    repeat (5) @(posedge clk);
    #1; req_valid = 1'b0;
    tests++; if (busy_ready != 0) begin fails++; $display("FAIL busy_ready: got %0d want 0", busy_ready); end
    tests++; if (resp_count - rc0 != 2) begin fails++; $display("FAIL held_valid_resps: got %0d want 2", resp_count - rc0); end
    tests++; if (resp_rdata !== 32'hDE558001) begin fails++; $display("FAIL b2b_rdata: got %h want de558001", resp_rdata); end
  endtask

  task automatic test_misalign;
    int lat, we0; logic [31:0] rd; logic err;
    we0 = we_count;
    do_req(3'b000, 32'h11, 32'd0, lat, rd, err);
`ifdef MISALIGN_TRAP_EN
    tests++; if (err !== 1'b1 || rd !== 32'd0 || lat != 2) begin
      fails++; $display("FAIL misalign_lw: err %b rd %h lat %0d want 1/0/2", err, rd, lat);
    end
    do_req(3'b110, 32'h11, 32'h0000FFFF, lat, rd, err);
    tests++; if (err !== 1'b1 || lat != 2 || mem[4] !== 32'hDE558001) begin
      fails++; $display("FAIL misalign_sh: err %b lat %0d mem %h want 1/2/de558001", err, lat, mem[4]);
    end
`else
    tests++; if (err !== 1'b0 || rd !== 32'hDE558001) begin
      fails++; $display("FAIL unaligned_lw: err %b rd %h want 0/de558001", err, rd);
    end
`endif
    tests++; if (we_count != we0) begin fails++; $display("FAIL misalign_no_we: %0d pulses want 0", we_count - we0); end
  endtask

  initial begin
    test_reset();
    test_word();
    test_subword();
    test_out_of_range();
    test_back_to_back();
    test_reset_mid();
    test_misalign();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1);
  end

endmodule
